// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  typedef logic [29:0] WordAddrBus;
  typedef logic [31:0] WordDataBus;

  typedef enum logic [1:0] {
    IF_STATE_IDLE   = 2'd0,
    IF_STATE_REQ    = 2'd1,
    IF_STATE_ACCESS = 2'd2,
    IF_STATE_HOLD   = 2'd3
  } IfStateBus;

  localparam WordDataBus ISA_NOP = 32'h0000_0000;

  // Word-address increment; wraps mod 2^30.
  function automatic WordAddrBus pc_incr(input WordAddrBus pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Shared-bus signal bundle between a fetch master and the bus/memory side.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       bus_req_;
  logic       bus_grnt_;
  logic       bus_as_;
  logic       bus_rw;
  WordAddrBus bus_addr;
  WordDataBus bus_wr_data;
  WordDataBus bus_rd_data;
  logic       bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/if_stage_if_reg.sv
// IF/ID pipeline register: reset, then flush, then load, then stall-hold, else bubble.
module if_stage_if_reg
  import if_stage_pkg::*;
#(
  parameter WordAddrBus RESET_PC = 30'h0,
  parameter WordDataBus NOP_INSN = ISA_NOP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       load_i,
  input  WordAddrBus load_pc_i,
  input  WordDataBus load_insn_i,
  output WordAddrBus if_pc_o,
  output WordDataBus if_insn_o,
  output logic       if_en_o
);

  WordAddrBus pc_q, pc_d;
  WordDataBus insn_q, insn_d;
  logic       en_q, en_d;

  always_comb begin
    pc_d   = pc_q;
    insn_d = insn_q;
    en_d   = en_q;
    if (flush_i) begin
      en_d   = 1'b0;
      insn_d = NOP_INSN;
    end else if (load_i) begin
      pc_d   = load_pc_i;
      insn_d = load_insn_i;
      en_d   = 1'b1;
    end else if (!stall_i) begin
      en_d   = 1'b0;
      insn_d = NOP_INSN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      insn_q <= NOP_INSN;
      en_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      insn_q <= insn_d;
      en_q   <= en_d;
    end
  end

  assign if_pc_o   = pc_q;
  assign if_insn_o = insn_q;
  assign if_en_o   = en_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, bus-master fetch FSM and hold buffer feeding IF/ID.
// Optional scratchpad fetch path is enabled by defining IF_SPM_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter WordAddrBus RESET_PC = 30'h0,
  parameter WordDataBus NOP_INSN = ISA_NOP
`ifdef IF_SPM_EN
  ,
  parameter WordAddrBus  SPM_BASE       = 30'h0,
  parameter int unsigned SPM_DEPTH_LOG2 = 12
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  WordAddrBus        new_pc,
  input  logic              br_taken,
  input  WordAddrBus        br_addr,
  output logic              busy,
  if_stage_if.master        bus,
  output WordAddrBus        if_pc,
  output WordDataBus        if_insn,
  output logic              if_en
`ifdef IF_SPM_EN
  ,
  output WordAddrBus        spm_addr,
  output logic              spm_as_,
  input  WordDataBus        spm_rd_data
`endif
);

  IfStateBus  state_q, state_d;
  WordAddrBus pc_q, pc_d;
  WordAddrBus addr_q, addr_d;
  WordDataBus buf_q, buf_d;
  logic       drop_q, drop_d;

  WordAddrBus next_pc;
  logic       fetch_ok;
  logic       load;
  WordDataBus load_insn;
  logic       spm_hit;
  WordDataBus spm_data;

  assign next_pc  = br_taken ? br_addr : pc_incr(pc_q);
  // Reset gating keeps the bus idle while reset is held.
  assign fetch_ok = !reset && !stall && !flush;

`ifdef IF_SPM_EN
  assign spm_hit  = ((pc_q - SPM_BASE) >> SPM_DEPTH_LOG2) == '0;
  assign spm_data = spm_rd_data;
  assign spm_addr = pc_q;
  assign spm_as_  = !((state_q == IF_STATE_IDLE) && spm_hit && fetch_ok);
`else
  assign spm_hit  = 1'b0;
  assign spm_data = NOP_INSN;
`endif

  assign bus.bus_rw      = 1'b1;
  assign bus.bus_wr_data = '0;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    drop_d       = drop_q;
    load         = 1'b0;
    load_insn    = buf_q;
    bus.bus_req_ = 1'b1;
    bus.bus_as_  = 1'b1;
    bus.bus_addr = addr_q;

    unique case (state_q)
      IF_STATE_IDLE: begin
        if (fetch_ok && spm_hit) begin
          load      = 1'b1;
          load_insn = spm_data;
          pc_d      = next_pc;
        end else if (fetch_ok) begin
          bus.bus_req_ = 1'b0;
          state_d      = IF_STATE_REQ;
        end
      end
      IF_STATE_REQ: begin
        bus.bus_req_ = 1'b0;
        if (!bus.bus_grnt_) begin
          bus.bus_as_  = 1'b0;
          bus.bus_addr = pc_q;
          addr_d       = pc_q;
          state_d      = IF_STATE_ACCESS;
        end
      end
      IF_STATE_ACCESS: begin
        bus.bus_req_ = 1'b0;
        if (!bus.bus_rdy_) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IF_STATE_IDLE;
          end else if (stall) begin
            buf_d   = bus.bus_rd_data;
            state_d = IF_STATE_HOLD;
          end else begin
            load      = 1'b1;
            load_insn = bus.bus_rd_data;
            pc_d      = next_pc;
            state_d   = IF_STATE_IDLE;
          end
        end
      end
      IF_STATE_HOLD: begin
        if (flush) begin
          state_d = IF_STATE_IDLE;
        end else if (!stall) begin
          load    = 1'b1;
          pc_d    = next_pc;
          state_d = IF_STATE_IDLE;
        end
      end
    endcase

    // A flushed in-flight transaction still runs to completion; its data is dropped.
    if (flush) begin
      pc_d = new_pc;
      if ((state_q == IF_STATE_REQ || state_q == IF_STATE_ACCESS) &&
          state_d != IF_STATE_IDLE) begin
        drop_d = 1'b1;
      end
    end
  end

  assign busy = (state_q == IF_STATE_REQ || state_q == IF_STATE_ACCESS) && bus.bus_rdy_;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IF_STATE_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      buf_q   <= NOP_INSN;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  if_stage_if_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INSN (NOP_INSN)
  ) u_if_reg (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall),
    .flush_i     (flush),
    .load_i      (load),
    .load_pc_i   (pc_q),
    .load_insn_i (load_insn),
    .if_pc_o     (if_pc),
    .if_insn_o   (if_insn),
    .if_en_o     (if_en)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vectors for if_stage; bus grant/ready/data are driven per row.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct {
    logic        stall, flush, grnt_n, rdy_n, br_taken;
    logic [29:0] br_addr, new_pc;
    logic [31:0] rd_data;
    logic        e_busy, e_req_n, e_as_n, chk_addr;
    logic [29:0] e_addr;
    logic        e_en;
    logic [31:0] e_insn;
    logic [29:0] e_pc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  WordAddrBus new_pc = '0, br_addr = '0;
  logic       busy;
  WordAddrBus if_pc;
  WordDataBus if_insn;
  logic       if_en;
  int         n_chk = 0, n_pass = 0;

  if_stage_if bus_if ();

`ifdef IF_SPM_EN
  localparam WordAddrBus SpmBase = 30'h2000_0000;
  WordAddrBus spm_addr;
  logic       spm_as_;
  WordDataBus spm_rd_data;
  assign spm_rd_data = {2'b01, spm_addr};
`endif

  if_stage #(
    .RESET_PC (30'h0),
    .NOP_INSN (32'h0)
`ifdef IF_SPM_EN
    ,
    .SPM_BASE       (SpmBase),
    .SPM_DEPTH_LOG2 (12)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .busy        (busy),
    .bus         (bus_if),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en)
`ifdef IF_SPM_EN
    ,
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rd_data (spm_rd_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [31:0] st, fl, gn, rn, bt, ba, np, rd,
                             input logic [31:0] eb, erq, eas, ca, ea, een, ein, epc);
    vec_t r;
    r.stall = st[0];   r.flush = fl[0];   r.grnt_n = gn[0]; r.rdy_n = rn[0];
    r.br_taken = bt[0]; r.br_addr = ba[29:0]; r.new_pc = np[29:0]; r.rd_data = rd;
    r.e_busy = eb[0];  r.e_req_n = erq[0]; r.e_as_n = eas[0]; r.chk_addr = ca[0];
    r.e_addr = ea[29:0]; r.e_en = een[0]; r.e_insn = ein; r.e_pc = epc[29:0];
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
  endtask

  task automatic chk_row(input int row, input vec_t r);
    chk("busy", row, 32'(busy), 32'(r.e_busy));
    chk("bus_req_", row, 32'(bus_if.bus_req_), 32'(r.e_req_n));
    chk("bus_as_", row, 32'(bus_if.bus_as_), 32'(r.e_as_n));
    if (r.chk_addr) chk("bus_addr", row, 32'(bus_if.bus_addr), 32'(r.e_addr));
    chk("if_en", row, 32'(if_en), 32'(r.e_en));
    chk("if_insn", row, if_insn, r.e_insn);
    chk("if_pc", row, 32'(if_pc), 32'(r.e_pc));
  endtask

  vec_t tbl[$];

  initial begin
    // st fl gn rn bt ba np rd | busy req as chkaddr addr | en insn pc
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,0,            0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,'h1234_5678,  0,0,1,1,0,            0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            1,'h1234_5678,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,1,            0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,1,0,0,0,0, 1,0,1,1,1, 0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,'hA000_0001,  0,0,1,1,1,            0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            1,'hA000_0001,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,2,            0,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0,'hB000_0002,  0,0,1,1,2,            0,0,1));
    tbl.push_back(v(1,0,0,1,0,0,0,0,            0,1,1,0,0,            0,0,1));
    tbl.push_back(v(1,0,0,1,0,0,0,0,            0,1,1,0,0,            0,0,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,1,1,0,0,            0,0,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            1,'hB000_0002,2));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,3,            0,0,2));
    tbl.push_back(v(0,1,0,1,0,0,'h100,0,        1,0,1,1,3,            0,0,2));
    tbl.push_back(v(0,0,0,0,0,0,0,'hDEAD_BEEF,  0,0,1,1,3,            0,0,2));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            0,0,2));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,'h100,        0,0,2));
    tbl.push_back(v(0,0,0,0,1,'h40,0,'hC000_0100, 0,0,1,1,'h100,      0,0,2));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            1,'hC000_0100,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,'h40,         0,0,'h100));
    tbl.push_back(v(0,1,0,0,1,'h55,'h200,'hD000_0040, 0,0,1,1,'h40,   0,0,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            0,0,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,'h200,        0,0,'h100));
    tbl.push_back(v(0,1,0,0,0,0,'h3FFF_FFFF,'hE000_0200, 0,0,1,1,'h200, 0,0,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            0,0,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,'h3FFF_FFFF,  0,0,'h100));
    tbl.push_back(v(0,0,0,0,0,0,0,'hF000_0000,  0,0,1,1,'h3FFF_FFFF,  0,0,'h100));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            1,'hF000_0000,'h3FFF_FFFF));
    tbl.push_back(v(0,0,1,1,0,0,0,0,            1,0,1,0,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(1,0,0,0,0,0,0,'h1111_1111,  0,0,1,1,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(1,1,0,1,0,0,7,0,            0,1,1,0,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(1,0,0,1,0,0,0,0,            0,1,1,0,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            0,0,1,0,0,            0,0,'h3FFF_FFFF));
    tbl.push_back(v(0,0,0,1,0,0,0,0,            1,0,0,1,7,            0,0,'h3FFF_FFFF));

    bus_if.bus_grnt_   = 1'b0;
    bus_if.bus_rdy_    = 1'b1;
    bus_if.bus_rd_data = '0;

    // Reset state with an otherwise idle, unstalled pipeline.
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_req", 0, 32'(bus_if.bus_req_), 32'd1);
    chk("rst_as", 0, 32'(bus_if.bus_as_), 32'd1);
    chk("rst_addr", 0, 32'(bus_if.bus_addr), 32'd0);
    chk("rst_en", 0, 32'(if_en), 32'd0);
    chk("rst_insn", 0, if_insn, 32'd0);
    chk("rst_pc", 0, 32'(if_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      stall              = tbl[i].stall;
      flush              = tbl[i].flush;
      new_pc             = tbl[i].new_pc;
      br_taken           = tbl[i].br_taken;
      br_addr            = tbl[i].br_addr;
      bus_if.bus_grnt_   = tbl[i].grnt_n;
      bus_if.bus_rdy_    = tbl[i].rdy_n;
      bus_if.bus_rd_data = tbl[i].rd_data;
      @(negedge clk);
      chk_row(i + 1, tbl[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-transaction, between clock edges.
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    bus_if.bus_rdy_ = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 99, 32'(busy), 32'd0);
    chk("arst_req", 99, 32'(bus_if.bus_req_), 32'd1);
    chk("arst_en", 99, 32'(if_en), 32'd0);
    chk("arst_pc", 99, 32'(if_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

`ifdef IF_SPM_EN
    // Redirect into the scratchpad: one instruction per cycle, bus untouched.
    flush  = 1'b1;
    new_pc = SpmBase;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("spm_as", 200, 32'(spm_as_), 32'd0);
    chk("spm_addr", 200, 32'(spm_addr), 32'(SpmBase));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("spm_en", 201 + k, 32'(if_en), 32'd1);
      chk("spm_pc", 201 + k, 32'(if_pc), 32'(SpmBase + 30'(k)));
      chk("spm_insn", 201 + k, if_insn, {2'b01, SpmBase + 30'(k)});
      chk("spm_req", 201 + k, 32'(bus_if.bus_req_), 32'd1);
      chk("spm_busy", 201 + k, 32'(busy), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage. Owns the program counter and fetches one instruction word per access over the shared bus as a bus master. It presents the IF/ID pipeline register (if_pc, if_insn, if_en) to the decode stage directly downstream. It honours stall, flush and branch redirects from pipeline control and decode, and raises busy while a fetch is outstanding.

Parameters:
RESET_PC, 30'h0, word address loaded into the PC on reset
NOP_INSN, 32'h0, instruction word driven on if_insn when if_en=0

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
stall  in  1  hold PC and IF/ID register
flush  in  1  discard fetched instruction, redirect to new_pc
new_pc  in  30  redirect target on flush (word address)
br_taken  in  1  branch taken (from decode)
br_addr  in  30  branch target (word address)
busy  out  1  fetch outstanding; pipeline control stalls other stages
bus_req_  out  1  bus request, active-low
bus_grnt_  in  1  bus grant, active-low
bus_as_  out  1  address strobe, active-low
bus_rw  out  1  constant 1 (read)
bus_addr  out  30  fetch address
bus_wr_data  out  32  constant 0
bus_rd_data  in  32  read data
bus_rdy_  in  1  ready, active-low
if_pc  out  30  PC of the instruction in IF/ID
if_insn  out  32  instruction in IF/ID
if_en  out  1  IF/ID contents valid

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=IDLE, if_pc=RESET_PC, if_insn=NOP_INSN, if_en=0, bus_req_=1, bus_as_=1, bus_addr=0, busy=0, hold buffer empty.
- FSM states: IDLE, REQ, ACCESS, HOLD.
- IDLE:
  - bus_req_=1.
  - If !stall and !flush: assert bus_req_ combinationally and go to REQ next edge.
- REQ:
  - bus_req_=0.
  - When bus_grnt_=0: bus_as_=0 and bus_addr=pc this cycle; go to ACCESS.
- ACCESS:
  - bus_req_=0; bus_addr=pc held.
  - When bus_rdy_=0 and !stall: load IF/ID with if_pc=pc, if_insn=bus_rd_data, if_en=1; pc<=next_pc; go to IDLE.
  - When bus_rdy_=0 and stall: capture the word into the hold buffer; go to HOLD.
- HOLD:
  - Bus released.
  - When stall drops: load IF/ID from the buffer; pc<=next_pc; go to IDLE.
- next_pc selection: br_taken ? br_addr : pc+1. Wrap is mod 2^30, so 30'h3FFFFFFF+1 -> 0.
- Default IF/ID behaviour:
  - If no instruction loads in a cycle and !stall: if_en<=0, if_insn<=NOP_INSN.
  - stall holds all IF/ID fields.
- Flush, highest priority:
  - IF/ID cleared (if_en=0, if_insn=NOP_INSN), pc<=new_pc, buffer discarded.
  - If flush occurs in REQ or ACCESS, the bus transaction still completes and the data is dropped; then go to IDLE.
  - Flush in HOLD: go to IDLE immediately.
  - Flush overrides stall and br_taken in the same cycle.
- br_taken is sampled only on the edge an instruction is delivered. Decode asserts it in the cycle after the branch enters IF/ID; a fetch already in flight completes and the fetched word is replaced by the target.
- busy=1 in REQ and ACCESS while bus_rdy_=1; busy=0 otherwise.
- Minimum bus fetch latency: 3 cycles from IDLE to if_en=1 with immediate grant and ready.

Optional Feature:
- Macro IF_SPM_EN.
- Defined: adds ports spm_addr (out 30), spm_as_ (out 1), spm_rd_data (in 32), plus parameters SPM_BASE (30'h0) and SPM_DEPTH_LOG2 (12).
  - When pc lies in [SPM_BASE, SPM_BASE+2^SPM_DEPTH_LOG2), the fetch bypasses the FSM.
  - spm_as_=0 from IDLE; data loads into IF/ID next edge. Throughput 1 instruction/cycle, busy=0, bus untouched.
  - Stall/flush/branch rules are identical.
- Undefined: all addresses use the bus FSM; SPM ports absent.

Decomposition:
- Shared cpu package:
  - IfStateBus (2 bits) with IF_STATE_IDLE/REQ/ACCESS/HOLD encodings.
  - WordAddrBus (29:0) and WordDataBus (31:0).
  - ISA_NOP value.
- One sub-module, if_reg: the IF/ID pipeline register implementing the reset, stall, flush and load priorities.
- Top level holds pc, the FSM and the hold buffer.

Test Plan:
- Reset released, grant/ready immediate, memory[0]=32'h1234_5678 -> bus_addr=0 in cycle 2; if_en=1, if_insn=32'h1234_5678, if_pc=0 after cycle 3; next fetch addr 1.
- bus_rdy_ delayed 4 cycles -> busy=1 throughout, if_en=0 with if_insn=0 until data arrives, then a single valid pulse.
- stall asserted in the cycle bus_rdy_=0, held 3 cycles -> word held in HOLD; IF/ID unchanged; on release if_insn=buffered word; pc increments exactly once.
- flush with new_pc=30'h100 mid-ACCESS -> current word discarded, if_en=0; next bus_addr=30'h100.
- br_taken=1, br_addr=30'h40 on a delivery edge -> next fetch addr 30'h40, not pc+1. Flush asserted in the same cycle -> new_pc wins.
- IF_SPM_EN defined, pc=SPM_BASE -> consecutive if_en=1 every cycle, bus_req_ stays 1, if_pc increments by 1 per cycle.
